// File: rtl/rst_ckpt_if.sv
// Dispatch-side port bundle for the register status table:
// rename write plus the two operand status lookups.
interface rst_ckpt_if #(
  parameter int W_ADDR = 5,
  parameter int W_TAG  = 6
);
  logic [W_ADDR-1:0] dispatch_rsaddr;
  logic [W_ADDR-1:0] dispatch_rtaddr;
  logic [W_TAG-1:0]  dispatch_rstag;
  logic [W_TAG-1:0]  dispatch_rttag;
  logic              dispatch_rsvalid;
  logic              dispatch_rtvalid;
  logic [W_ADDR-1:0] dispatch_addr;
  logic [W_TAG-1:0]  dispatch_tag;
  logic              dispatch_valid;

  modport master (
    output dispatch_rsaddr, dispatch_rtaddr,
    output dispatch_addr, dispatch_tag, dispatch_valid,
    input  dispatch_rstag, dispatch_rttag,
    input  dispatch_rsvalid, dispatch_rtvalid
  );

  modport slave (
    input  dispatch_rsaddr, dispatch_rtaddr,
    input  dispatch_addr, dispatch_tag, dispatch_valid,
    output dispatch_rstag, dispatch_rttag,
    output dispatch_rsvalid, dispatch_rtvalid
  );
endinterface

// File: rtl/rst_ckpt.sv
// Register status table with multi-channel CDB clears
// and whole-table branch checkpoints.
module rst_ckpt #(
  parameter int W_ADDR = 5,
  parameter int W_TAG  = 6,
  parameter int N_CDB  = 2,
  parameter int W_CKPT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  rst_ckpt_if.slave                  d,
  input  logic [N_CDB*W_TAG-1:0]     cdb_tag,
  input  logic [N_CDB-1:0]           cdb_valid,
  input  logic                       ckpt_save,
  input  logic [W_CKPT-1:0]          ckpt_save_id,
  input  logic                       ckpt_restore,
  input  logic [W_CKPT-1:0]          ckpt_restore_id,
  input  logic                       flush,
  output logic [2**W_ADDR-1:0]       regfile_wen_onehot,
  output logic [2**W_ADDR*N_CDB-1:0] regfile_cdb_onehot,
  output logic [W_ADDR:0]            busy_count,
  output logic                       rst_error
);
  localparam int N_ENTRY = 2**W_ADDR;
  localparam int N_CKPT  = 2**W_CKPT;

  logic             r_v  [N_ENTRY];
  logic [W_TAG-1:0] r_t  [N_ENTRY];
  logic             r_sv [N_CKPT][N_ENTRY];
  logic [W_TAG-1:0] r_st [N_CKPT][N_ENTRY];
  logic [W_ADDR:0]  r_cnt;
  logic             r_err;

  logic             w_clr  [N_ENTRY];
  logic             w_sclr [N_CKPT][N_ENTRY];
  logic             w_nv   [N_ENTRY];
  logic [W_TAG-1:0] w_nt   [N_ENTRY];
  logic             w_snv  [N_CKPT][N_ENTRY];
  logic [W_TAG-1:0] w_snt  [N_CKPT][N_ENTRY];
  logic [W_ADDR:0]  w_cnt;
  logic             w_err;
  logic             w_seen [N_CDB];
  logic             w_shit [N_CDB];
  logic             w_won;
  logic             w_hit;

  // CAM: lowest channel wins per entry; also collect protocol errors
  always_comb begin
    regfile_wen_onehot = '0;
    regfile_cdb_onehot = '0;
    w_err = 1'b0;
    for (int c = 0; c < N_CDB; c++) begin
      w_seen[c] = 1'b0;
      w_shit[c] = 1'b0;
    end
    for (int r = 0; r < N_ENTRY; r++) begin
      w_clr[r] = 1'b0;
      w_won    = 1'b0;
      for (int c = 0; c < N_CDB; c++) begin
        w_hit = r_v[r] && cdb_valid[c] &&
                cdb_tag[c*W_TAG +: W_TAG] == r_t[r];
        if (w_hit) begin
          if (w_seen[c]) w_err = 1'b1;
          w_seen[c] = 1'b1;
          w_clr[r]  = 1'b1;
          if (!w_won) regfile_cdb_onehot[r*N_CDB+c] = 1'b1;
          w_won = 1'b1;
        end
      end
      regfile_wen_onehot[r] = w_clr[r];
    end
    for (int k = 0; k < N_CKPT; k++) begin
      for (int r = 0; r < N_ENTRY; r++) begin
        w_sclr[k][r] = 1'b0;
        for (int c = 0; c < N_CDB; c++) begin
          if (r_sv[k][r] && cdb_valid[c] &&
              cdb_tag[c*W_TAG +: W_TAG] == r_st[k][r]) begin
            w_sclr[k][r] = 1'b1;
            w_shit[c]    = 1'b1;
          end
        end
      end
    end
    for (int c = 0; c < N_CDB; c++) begin
      if (cdb_valid[c] && !w_seen[c] && !w_shit[c]) w_err = 1'b1;
      for (int c2 = c + 1; c2 < N_CDB; c2++) begin
        if (cdb_valid[c] && cdb_valid[c2] &&
            cdb_tag[c*W_TAG +: W_TAG] == cdb_tag[c2*W_TAG +: W_TAG])
          w_err = 1'b1;
      end
    end
  end

  // Next-state: flush > restore > dispatch/save, CDB clears everywhere
  always_comb begin
    for (int r = 0; r < N_ENTRY; r++) begin
      w_nv[r] = r_v[r] & ~w_clr[r];
      w_nt[r] = w_clr[r] ? '0 : r_t[r];
    end
    for (int k = 0; k < N_CKPT; k++) begin
      for (int r = 0; r < N_ENTRY; r++) begin
        w_snv[k][r] = r_sv[k][r] & ~w_sclr[k][r];
        w_snt[k][r] = w_sclr[k][r] ? '0 : r_st[k][r];
      end
    end
    if (ckpt_restore) begin
      for (int r = 0; r < N_ENTRY; r++) begin
        w_nv[r] = w_snv[ckpt_restore_id][r];
        w_nt[r] = w_snt[ckpt_restore_id][r];
      end
    end else begin
      if (d.dispatch_valid && d.dispatch_addr != '0) begin
        w_nv[d.dispatch_addr] = 1'b1;
        w_nt[d.dispatch_addr] = d.dispatch_tag;
      end
      if (ckpt_save) begin
        for (int r = 0; r < N_ENTRY; r++) begin
          w_snv[ckpt_save_id][r] = w_nv[r];
          w_snt[ckpt_save_id][r] = w_nt[r];
        end
      end
    end
    if (flush) begin
      for (int r = 0; r < N_ENTRY; r++) begin
        w_nv[r] = 1'b0;
        w_nt[r] = '0;
      end
      for (int k = 0; k < N_CKPT; k++) begin
        for (int r = 0; r < N_ENTRY; r++) begin
          w_snv[k][r] = 1'b0;
          w_snt[k][r] = '0;
        end
      end
    end
    w_cnt = '0;
    for (int r = 0; r < N_ENTRY; r++)
      w_cnt = w_cnt + (W_ADDR+1)'(w_nv[r]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < N_ENTRY; r++) begin
        r_v[r] <= 1'b0;
        r_t[r] <= '0;
      end
      for (int k = 0; k < N_CKPT; k++) begin
        for (int r = 0; r < N_ENTRY; r++) begin
          r_sv[k][r] <= 1'b0;
          r_st[k][r] <= '0;
        end
      end
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      for (int r = 0; r < N_ENTRY; r++) begin
        r_v[r] <= w_nv[r];
        r_t[r] <= w_nt[r];
      end
      for (int k = 0; k < N_CKPT; k++) begin
        for (int r = 0; r < N_ENTRY; r++) begin
          r_sv[k][r] <= w_snv[k][r];
          r_st[k][r] <= w_snt[k][r];
        end
      end
      r_cnt <= w_cnt;
      r_err <= r_err | w_err;
    end
  end

  assign d.dispatch_rstag   = r_t[d.dispatch_rsaddr];
  assign d.dispatch_rttag   = r_t[d.dispatch_rtaddr];
  assign d.dispatch_rsvalid = r_v[d.dispatch_rsaddr] &
                              ~w_clr[d.dispatch_rsaddr];
  assign d.dispatch_rtvalid = r_v[d.dispatch_rtaddr] &
                              ~w_clr[d.dispatch_rtaddr];
  assign busy_count = r_cnt;
  assign rst_error  = r_err;
endmodule

// File: tb/tb_rst_ckpt.sv
// Directed bench for rst_ckpt: rename, CDB clears,
// checkpoint save/restore, flush and error flag.
module tb_rst_ckpt;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] cdb_tag;
  logic [1:0]  cdb_valid;
  logic        ckpt_save, ckpt_restore, flush;
  logic        ckpt_save_id, ckpt_restore_id;
  logic [31:0] wen;
  logic [63:0] cdb1h;
  logic [5:0]  busy;
  logic        err;
  int          n_chk = 0;
  int          n_fail = 0;

  rst_ckpt_if #(.W_ADDR(5), .W_TAG(6)) d ();

  rst_ckpt dut (
    .clk(clk), .reset(reset), .d(d),
    .cdb_tag(cdb_tag), .cdb_valid(cdb_valid),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore),
    .ckpt_restore_id(ckpt_restore_id),
    .flush(flush),
    .regfile_wen_onehot(wen),
    .regfile_cdb_onehot(cdb1h),
    .busy_count(busy), .rst_error(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    d.dispatch_valid = 1'b0;
    d.dispatch_addr  = '0;
    d.dispatch_tag   = '0;
    cdb_valid        = '0;
    cdb_tag          = '0;
    ckpt_save        = 1'b0;
    ckpt_restore     = 1'b0;
    ckpt_save_id     = 1'b0;
    ckpt_restore_id  = 1'b0;
    flush            = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic disp(input logic [4:0] a,
                      input logic [5:0] t);
    d.dispatch_valid = 1'b1;
    d.dispatch_addr  = a;
    d.dispatch_tag   = t;
  endtask

  task automatic rd(input logic [4:0] rs,
                    input logic [4:0] rt);
    d.dispatch_rsaddr = rs;
    d.dispatch_rtaddr = rt;
    #1;
  endtask

  initial begin
    idle();
    rd(5'd0, 5'd0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    rd(5'd5, 5'd9);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rsv", d.dispatch_rsvalid, 0);
    chk("rst_rstag", d.dispatch_rstag, 0);
    chk("rst_wen", wen, 0);

    disp(5'd5, 6'h12);
    tick();
    rd(5'd5, 5'd9);
    chk("d5_v", d.dispatch_rsvalid, 1);
    chk("d5_tag", d.dispatch_rstag, 6'h12);
    chk("d5_busy", busy, 1);

    disp(5'd9, 6'h20);
    tick();
    chk("d9_busy", busy, 2);
    cdb_tag = {6'h20, 6'h12};
    cdb_valid = 2'b11;
    rd(5'd5, 5'd9);
    chk("cdb_wen", wen, (64'd1 << 5) | (64'd1 << 9));
    chk("cdb_1h", cdb1h, (64'd1 << 10) | (64'd1 << 19));
    chk("cdb_rsbyp", d.dispatch_rsvalid, 0);
    chk("cdb_rtbyp", d.dispatch_rtvalid, 0);
    tick();
    chk("cdb_busy", busy, 0);
    chk("cdb_err", err, 0);

    disp(5'd7, 6'h03);
    tick();
    disp(5'd7, 6'h05);
    cdb_tag = {6'h00, 6'h03};
    cdb_valid = 2'b01;
    #1;
    chk("dpri_wen", wen, 64'd1 << 7);
    tick();
    rd(5'd7, 5'd0);
    chk("dpri_v", d.dispatch_rsvalid, 1);
    chk("dpri_tag", d.dispatch_rstag, 6'h05);
    chk("dpri_busy", busy, 1);
    cdb_tag = {6'h00, 6'h05};
    cdb_valid = 2'b01;
    tick();
    chk("r7clr_busy", busy, 0);

    disp(5'd3, 6'h08);
    tick();
    ckpt_save = 1'b1;
    ckpt_save_id = 1'b1;
    tick();
    disp(5'd3, 6'h09);
    tick();
    disp(5'd4, 6'h0A);
    tick();
    chk("ck_busy2", busy, 2);
    cdb_tag = {6'h00, 6'h08};
    cdb_valid = 2'b01;
    #1;
    chk("ck_wen0", wen, 0);
    tick();
    ckpt_restore = 1'b1;
    ckpt_restore_id = 1'b1;
    tick();
    rd(5'd3, 5'd4);
    chk("ck_r3", d.dispatch_rsvalid, 0);
    chk("ck_r4", d.dispatch_rtvalid, 0);
    chk("ck_busy0", busy, 0);
    chk("ck_err", err, 0);

    disp(5'd0, 6'h3F);
    tick();
    rd(5'd0, 5'd0);
    chk("r0_v", d.dispatch_rsvalid, 0);
    chk("r0_tag", d.dispatch_rstag, 0);
    chk("r0_busy", busy, 0);

    disp(5'd2, 6'h11);
    tick();
    cdb_tag = {6'h11, 6'h11};
    cdb_valid = 2'b11;
    #1;
    chk("dup_1h", cdb1h, 64'd1 << 4);
    chk("dup_wen", wen, 64'd1 << 2);
    tick();
    chk("dup_err", err, 1);
    chk("dup_busy", busy, 0);
    disp(5'd6, 6'h01);
    tick();
    chk("fl_pre", busy, 1);
    flush = 1'b1;
    tick();
    chk("fl_busy", busy, 0);
    chk("fl_err", err, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rst_ckpt.md
# rst_ckpt

Parametrised register status table for the Tomasulo dispatch path with multiple CDB channels and branch checkpoints. It tracks, per architectural register, whether a result is pending and which tag will produce it. It clears entries when any CDB channel publishes a matching tag and emits per-register/per-channel regfile write enables. It saves and restores whole-table snapshots for misprediction recovery. It sits between the dispatch unit, the CDB arbiter outputs and the register file.

## Interface
- W_ADDR, 5, register address width; N_ENTRY = 2**W_ADDR
- W_TAG, 6, tag width
- N_CDB, 2, number of CDB channels (1..4)
- W_CKPT, 1, checkpoint id width; N_CKPT = 2**W_CKPT snapshot slots

Ports:
- clk  in  1  clock; one clock, all state on rising edge
- reset  in  1  synchronous, active-high
- dispatch_rsaddr, dispatch_rtaddr  in  W_ADDR  read addresses
- dispatch_rstag, dispatch_rttag  out  W_TAG  pending tag of rs/rt
- dispatch_rsvalid, dispatch_rtvalid  out  1  1 = operand still pending
- dispatch_addr  in  W_ADDR  destination register being renamed
- dispatch_tag  in  W_TAG  new tag
- dispatch_valid  in  1  rename write strobe
- cdb_tag  in  N_CDB*W_TAG  channel c at [c*W_TAG +: W_TAG]
- cdb_valid  in  N_CDB  per-channel publish strobe
- ckpt_save, ckpt_save_id  in  1, W_CKPT  snapshot strobe and slot
- ckpt_restore, ckpt_restore_id  in  1, W_CKPT  restore strobe and slot
- flush  in  1  invalidate every entry and every checkpoint
- regfile_wen_onehot  out  N_ENTRY  register r written by CDB this cycle
- regfile_cdb_onehot  out  N_ENTRY*N_CDB  bit r*N_CDB+c: register r takes channel c
- busy_count  out  W_ADDR+1  number of valid entries in the table
- rst_error  out  1  sticky protocol-violation flag

## Operation
- Entry = {valid, tag}. Entry 0 ($zero) is constant {0,0}; dispatch to address 0 is ignored.
- Read: combinational from registered table. validOut = entry.valid AND NOT (any c: cdb_valid[c] && cdb_tag[c]==entry.tag) (same-cycle CDB bypass). The tag is output regardless. Same-cycle dispatch writes are NOT bypassed to reads.
- CAM: for each entry r with valid=1 and each channel c with cdb_valid[c] and tag match: regfile_cdb_onehot[r*N_CDB+c]=1, subject to lowest c winning if several channels match. regfile_wen_onehot[r] = OR over its channels. The entry is cleared to {0,0} next cycle.
- Dispatch (dispatch_valid, addr≠0): entry <= {1, dispatch_tag}. This takes priority over a CDB clear of the same entry; regfile_wen for that entry still asserts that cycle.
- Checkpoints: every slot's entries receive the same CDB clears as the live table every cycle. Dispatch never writes slots.
- ckpt_save: slot[save_id] <= live table after this cycle's dispatch and CDB updates. Re-saving a slot overwrites it.
- ckpt_restore: live table <= slot[restore_id] with this cycle's CDB clears applied; dispatch_valid ignored; ckpt_save ignored.
- Priority per cycle: reset > flush > restore > normal (dispatch + CDB + save).
- flush: live table and all slots <= all {0,0}; regfile_wen outputs still follow that cycle's CDB matches.
- busy_count: popcount of the live table's valid bits, registered so it always equals the current table.
- rst_error set (sticky until reset) when any of these occurs:
  - two valid CDB channels carry the same tag;
  - one tag matches more than one valid live entry (all matching entries are still cleared);
  - cdb_valid with a tag matching no valid live entry and no slot entry.

## Timing
- Reset: all live entries and slots {0,0}; busy_count=0; rst_error=0; all read valids 0, tags 0; regfile outputs follow inputs (0 with no valid CDB).
- Reads and regfile enables are combinational, same cycle as inputs; table updates are visible in the cycle after the strobe (1-cycle latency).
- Reset asserted mid-sequence discards pending save/restore/dispatch in that cycle.
- No backpressure: every strobe is accepted in the cycle it is high.

## Test plan
- Reset, then dispatch r5 tag 0x12 → next cycle rs=5 reads valid=1 tag 0x12; busy_count=1.
- With r5=0x12 and r9=0x20 pending: CDB0 tag 0x12 and CDB1 tag 0x20 in the same cycle → wen bits 5 and 9 set, cdb_onehot bits 10 and 19 set; rsvalid(r5)=0 same cycle; busy_count=0 next cycle.
- Dispatch r7 tag 0x05 while CDB0 publishes r7's old tag 0x03 → wen[7]=1; r7 reads {1,0x05} next cycle.
- Save slot1 with r3=0x08; dispatch r3=0x09 and r4=0x0A; CDB0 publishes 0x08 then restore slot1 → r3 invalid, r4 invalid, busy_count=0.
- Dispatch to r0 tag 0x3F → r0 reads valid=0; busy_count unchanged.
- CDB0 and CDB1 both carry tag 0x11 → channel 0 wins; rst_error=1 and stays 1 until reset; flush clears the table but not rst_error.
